// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO family: depth limits and occupancy-width helpers.
package fifo_pkg;

    localparam int ADAPT_MIN_DEPTH = 2;

    typedef logic [31:0] word_count_t;

    // Occupancy must represent 0..depth inclusive, hence one bit more than the index.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular word buffer: register array, wrapping wr/rd indices and an occupancy counter.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_en_i,
    input  logic [BITS-1:0]               wr_data_i,
    input  logic                          rd_en_i,
    output logic [occ_width(DEPTH)-1:0]   occ_o,
    output logic [BITS-1:0]               head_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int OW = occ_width(DEPTH);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [OW-1:0]   occ_q, occ_d;

    always_comb begin
        wr_idx_d = wr_en_i ? wr_idx_q + IW'(1) : wr_idx_q;
        rd_idx_d = rd_en_i ? rd_idx_q + IW'(1) : rd_idx_q;
        occ_d    = occ_q;
        case ({wr_en_i, rd_en_i})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_q] <= wr_data_i;
        end
    end

    // Storage is not reset; masking with occupancy keeps the head at zero whenever empty.
    assign occ_o  = occ_q;
    assign head_o = (occ_q != '0) ? mem_q[rd_idx_q] : '0;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the FIFO's rd_en/empty/1-cycle-latency read port into a prefetched valid/ready stream.
// Optional accepted-word counter on p_word_count when FIFO_RD_ADAPT_STATS_EN is defined.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 2
) (
    input  logic            rd_clk,
    input  logic            rd_rst_n,
    output logic            p_fifo_rd_en,
    input  logic [BITS-1:0] p_fifo_rd_data,
    input  logic            p_fifo_rd_empty,
    output logic            p_out_valid,
    input  logic            p_out_ready,
    output logic [BITS-1:0] p_out_data
`ifdef FIFO_RD_ADAPT_STATS_EN
    ,
    output logic [31:0]     p_word_count
`endif
);

    localparam int OW = occ_width(DEPTH);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    if (DEPTH < ADAPT_MIN_DEPTH || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_rd_stream_adapter: DEPTH must be a power of two and at least 2");
    end

    logic          in_flight_q;
    logic [OW-1:0] occ;
    logic [OW-1:0] credit;
    logic          out_fire;

    fifo_skid_buf #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i     (rd_clk),
        .rst_ni    (rd_rst_n),
        .wr_en_i   (in_flight_q),
        .wr_data_i (p_fifo_rd_data),
        .rd_en_i   (out_fire),
        .occ_o     (occ),
        .head_o    (p_out_data)
    );

    assign p_out_valid = (occ != '0);
    assign out_fire    = p_out_valid && p_out_ready;
    assign credit      = occ + OW'(in_flight_q);

    // A slot freed by this cycle's transfer may be refilled by a pop issued in the same cycle.
    assign p_fifo_rd_en = rd_rst_n && !p_fifo_rd_empty &&
                          ((credit < DEPTH_C) || ((credit == DEPTH_C) && out_fire));

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= p_fifo_rd_en;
        end
    end

`ifdef FIFO_RD_ADAPT_STATS_EN
    word_count_t word_count_q, word_count_d;

    assign word_count_d = out_fire ? word_count_q + 32'd1 : word_count_q;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign p_word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter with a behavioural FIFO read-port model.
module tb_fifo_rd_stream_adapter;

    localparam int BITS  = 32;
    localparam int DEPTH = 2;

    logic            rd_clk = 1'b0;
    logic            rd_rst_n = 1'b1;
    logic            p_fifo_rd_en;
    logic [BITS-1:0] p_fifo_rd_data = '0;
    logic            p_fifo_rd_empty = 1'b1;
    logic            p_out_valid;
    logic            p_out_ready = 1'b0;
    logic [BITS-1:0] p_out_data;
`ifdef FIFO_RD_ADAPT_STATS_EN
    logic [31:0]     p_word_count;
`endif

    fifo_rd_stream_adapter #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) dut (
        .rd_clk          (rd_clk),
        .rd_rst_n        (rd_rst_n),
        .p_fifo_rd_en    (p_fifo_rd_en),
        .p_fifo_rd_data  (p_fifo_rd_data),
        .p_fifo_rd_empty (p_fifo_rd_empty),
        .p_out_valid     (p_out_valid),
        .p_out_ready     (p_out_ready),
        .p_out_data      (p_out_data)
`ifdef FIFO_RD_ADAPT_STATS_EN
        ,
        .p_word_count    (p_word_count)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          ready_pct = 0;
    int          gap_pct = 0;
    logic        last_pop = 1'b0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One read-domain cycle: present popped data, drive ready/empty, then sample the pop request.
    task automatic step();
        @(negedge rd_clk);
        if (last_pop) begin
            if (fifo_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_underflow: pop issued with model FIFO empty (cycle %0d)", cyc);
                p_fifo_rd_data = $urandom;
            end else begin
                p_fifo_rd_data = fifo_q.pop_front();
            end
        end else begin
            p_fifo_rd_data = $urandom;
        end
        p_out_ready     = (int'($urandom_range(99)) < ready_pct);
        p_fifo_rd_empty = (fifo_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
        #1;
        last_pop = p_fifo_rd_en;
        check("rd_en_while_empty", {31'd0, p_fifo_rd_en & p_fifo_rd_empty}, 32'd0);
        cyc++;
    endtask

    // Monitor: consumes expected words on every transfer and polices the valid/ready contract.
    initial begin : monitor
        logic        stall_prev;
        logic [31:0] data_prev;
        int          credit;
        stall_prev = 1'b0;
        data_prev  = '0;
        credit     = 0;
        forever begin
            @(negedge rd_clk);
            #2;
            if (!rd_rst_n) begin
                stall_prev = 1'b0;
                credit     = 0;
            end else begin
                if (stall_prev) begin
                    check("hold_valid", {31'd0, p_out_valid}, 32'd1);
                    check("hold_data", p_out_data, data_prev);
                end
                if (p_out_valid && p_out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got 0x%08h, expected no transfer", p_out_data);
                    end else begin
                        check("stream_data", p_out_data, exp_q.pop_front());
                    end
                end
                credit = credit + int'(p_fifo_rd_en) - int'(p_out_valid && p_out_ready);
                if (credit > DEPTH) begin
                    checks++;
                    errors++;
                    $display("FAIL credit_bound: got %0d, expected at most %0d", credit, DEPTH);
                end
                stall_prev = p_out_valid && !p_out_ready;
                data_prev  = p_out_data;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int c0;
        int nf;
        int np;
        int guard;

        #1 rd_rst_n = 1'b0;
        repeat (3) step();
        check("rst_valid", {31'd0, p_out_valid}, 32'd0);
        check("rst_data", p_out_data, 32'd0);
        rd_rst_n = 1'b1;

        // Idle with FIFO empty
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_rd_en", {31'd0, p_fifo_rd_en}, 32'd0);
            check("idle_valid", {31'd0, p_out_valid}, 32'd0);
            check("idle_data", p_out_data, 32'd0);
        end

        // Preloaded burst with ready held high
        ready_pct = 100;
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        guard = 0;
        do begin step(); guard++; end while (!p_fifo_rd_en && guard < 20);
        c0 = cyc;
        guard = 0;
        do begin step(); guard++; end while (!p_out_valid && guard < 10);
        check("first_valid_latency", 32'(cyc - c0), 32'd2);
        nf = int'(p_out_valid && p_out_ready);
        repeat (7) begin step(); nf += int'(p_out_valid && p_out_ready); end
        check("burst_consecutive", 32'(nf), 32'd8);
        repeat (4) step();
        check("burst_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure: only DEPTH words prefetched, head held
        ready_pct = 0;
        for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
        np = 0;
        repeat (12) begin step(); np += int'(p_fifo_rd_en); end
        check("stall_pops", 32'(np), 32'd2);
        check("stall_valid", {31'd0, p_out_valid}, 32'd1);
        check("stall_head", p_out_data, 32'h100);
        ready_pct = 100;
        nf = 0;
        repeat (16) begin step(); nf += int'(p_out_valid && p_out_ready); end
        check("resume_no_gaps", 32'(nf), 32'd16);
        repeat (3) step();
        check("resume_drained", 32'(exp_q.size()), 32'd0);

        // Random ready and empty gaps
        ready_pct = 50;
        gap_pct   = 25;
        for (int i = 0; i < 1000; i++) push_word($urandom);
        guard = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && guard < 20000) begin
            step();
            guard++;
        end
        check("random_drained", 32'(exp_q.size()), 32'd0);
        gap_pct = 0;

        // Asynchronous reset in the middle of a streaming burst
        ready_pct = 100;
        for (int i = 0; i < 8; i++) push_word(32'h500 + 32'(i));
        guard = 0;
        do begin step(); guard++; end while (!p_out_valid && guard < 10);
        step();
        #2 rd_rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, p_out_valid}, 32'd0);
        check("async_rst_data", p_out_data, 32'd0);
        check("async_rst_rd_en", {31'd0, p_fifo_rd_en}, 32'd0);
        fifo_q.delete();
        exp_q.delete();
        last_pop = 1'b0;
        repeat (2) step();
        rd_rst_n = 1'b1;
        push_word(32'hCAFE_0001);
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin step(); guard++; end
        check("post_rst_drained", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_RD_ADAPT_STATS_EN
        rd_rst_n = 1'b0;
        repeat (2) step();
        rd_rst_n = 1'b1;
        for (int i = 0; i < 300; i++) push_word(32'h3000 + 32'(i));
        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin step(); guard++; end
        repeat (2) step();
        check("word_count", p_word_count, 32'd300);
        rd_rst_n = 1'b0;
        #1;
        check("word_count_rst", p_word_count, 32'd0);
        repeat (2) step();
        rd_rst_n = 1'b1;
`endif

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
